// File: rtl/register_file_mp_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Default geometry, the hardwired-zero address and the write-counter saturation limit.
package register_file_mp_pkg;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefAddrW = 5;
    localparam int unsigned ZeroAddr = 0;
    localparam logic [7:0]  WrCntMax = 8'd255;

    // Add 0..2 committed writes to the debug counter, clamping at WrCntMax.
    function automatic logic [7:0] wrcnt_sat_add(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'b0, inc};
        return (sum > {1'b0, WrCntMax}) ? WrCntMax : sum[7:0];
    endfunction

endpackage

// File: rtl/register_file_mp_read_port.sv
// One combinational read port of the register file.
// Selects the stored word, forces register 0 to zero when enabled and forwards same-cycle write data.
module register_file_mp_read_port
    import register_file_mp_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] regs_i [2**ADDR_W],
    input  logic              wr_en0_i,
    input  logic [ADDR_W-1:0] wr_addr0_i,
    input  logic [DATA_W-1:0] wr_data0_i,
    input  logic              wr_en1_i,
    input  logic [ADDR_W-1:0] wr_addr1_i,
    input  logic [DATA_W-1:0] wr_data1_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic is_zero;
    logic hit0;
    logic hit1;

    // wr_en*_i are commit strobes: already masked by reset, zero-reg and collision.
    always_comb begin
        is_zero = ZERO_REG && (rd_addr_i == ADDR_W'(ZeroAddr));
        hit0    = BYPASS && wr_en0_i && (wr_addr0_i == rd_addr_i);
        hit1    = BYPASS && wr_en1_i && (wr_addr1_i == rd_addr_i);

        if (is_zero) begin
            rd_data_o = '0;
        end else if (hit1) begin
            rd_data_o = wr_data1_i;
        end else if (hit0) begin
            rd_data_o = wr_data0_i;
        end else begin
            rd_data_o = regs_i[rd_addr_i];
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file: NUM_RD read ports, two prioritised write ports,
// optional hardwired-zero R0, optional write-to-read bypass and a saturating write counter.
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [NUM_RD*ADDR_W-1:0] Adr,
    output logic [NUM_RD*DATA_W-1:0] Dout,
    input  logic                     WrEn0,
    input  logic [ADDR_W-1:0]        Awr0,
    input  logic [DATA_W-1:0]        Din0,
    input  logic                     WrEn1,
    input  logic [ADDR_W-1:0]        Awr1,
    input  logic [DATA_W-1:0]        Din1,
    output logic [7:0]               WrCnt
);

    localparam int unsigned Depth = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [Depth];
    logic [7:0]        wrcnt_q;
    logic [7:0]        wrcnt_d;
    logic              commit0;
    logic              commit1;

    // Port 1 wins an address collision, so port 0 only commits to a different address.
    always_comb begin
        commit1 = WrEn1 && !Rst && !(ZERO_REG && (Awr1 == ADDR_W'(ZeroAddr)));
        commit0 = WrEn0 && !Rst && !(ZERO_REG && (Awr0 == ADDR_W'(ZeroAddr)))
                  && !(WrEn1 && (Awr1 == Awr0));
        wrcnt_d = wrcnt_sat_add(wrcnt_q, {1'b0, commit0} + {1'b0, commit1});
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < Depth; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (commit0) begin
                regs_q[Awr0] <= Din0;
            end
            if (commit1) begin
                regs_q[Awr1] <= Din1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wrcnt_q <= '0;
        end else begin
            wrcnt_q <= wrcnt_d;
        end
    end

    assign WrCnt = wrcnt_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        register_file_mp_read_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_rd (
            .rd_addr_i (Adr[k*ADDR_W +: ADDR_W]),
            .regs_i    (regs_q),
            .wr_en0_i  (commit0),
            .wr_addr0_i(Awr0),
            .wr_data0_i(Din0),
            .wr_en1_i  (commit1),
            .wr_addr1_i(Awr1),
            .wr_data1_i(Din1),
            .rd_data_o (Dout[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench: default instance (zero-reg, bypass) alongside a 4-port 16-bit
// instance without zero-reg or bypass, both checked against a behavioural model.
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        we0, we1;
    logic [4:0]  a0, a1, ra0, ra1, ra2, ra3;
    logic [31:0] d0, d1;
    logic [63:0] dout_a;
    logic [63:0] dout_b;
    logic [7:0]  cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut_a (
        .Clk(clk), .Rst(rst), .Adr({ra1, ra0}), .Dout(dout_a),
        .WrEn0(we0), .Awr0(a0), .Din0(d0),
        .WrEn1(we1), .Awr1(a1), .Din1(d1), .WrCnt(cnt_a)
    );

    register_file_mp #(
        .DATA_W(16), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1'b0), .BYPASS(1'b0)
    ) dut_b (
        .Clk(clk), .Rst(rst), .Adr({ra3, ra2, ra1, ra0}), .Dout(dout_b),
        .WrEn0(we0), .Awr0(a0), .Din0(d0[15:0]),
        .WrEn1(we1), .Awr1(a1), .Din1(d1[15:0]), .WrCnt(cnt_b)
    );

    typedef struct packed {
        logic [31:0] a0, a1;
        logic [15:0] b0, b1, b2, b3;
        logic [7:0]  ca, cb;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];
    int          ma, mb;

    function automatic bit commit1(input bit zero);
        return (we1 === 1'b1) && (rst === 1'b0) && !(zero && a1 == 5'd0);
    endfunction

    function automatic bit commit0(input bit zero);
        return (we0 === 1'b1) && (rst === 1'b0) && !(zero && a0 == 5'd0)
               && !((we1 === 1'b1) && a1 == a0);
    endfunction

    function automatic logic [31:0] rd_exp(input bit zero, input bit bypass, input logic [4:0] addr,
                                           input logic [31:0] stored, input bit c0, input bit c1);
        if (zero && addr == 5'd0) return 32'd0;
        if (bypass && c1 && a1 == addr) return d1;
        if (bypass && c0 && a0 == addr) return d0;
        return stored;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit w0, input logic [4:0] wa0, input logic [31:0] wd0,
                        input bit w1, input logic [4:0] wa1, input logic [31:0] wd1,
                        input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] r3, input bit check);
        exp_t e;
        exp_t g;
        bit   ca0, ca1, cb0, cb1;
        @(negedge clk);
        rst = r; we0 = w0; a0 = wa0; d0 = wd0; we1 = w1; a1 = wa1; d1 = wd1;
        ra0 = r0; ra1 = r1; ra2 = r2; ra3 = r3;
        #1;
        ca0 = commit0(1'b1); ca1 = commit1(1'b1);
        cb0 = commit0(1'b0); cb1 = commit1(1'b0);
        e.a0 = rd_exp(1'b1, 1'b1, ra0, mem_a[ra0], ca0, ca1);
        e.a1 = rd_exp(1'b1, 1'b1, ra1, mem_a[ra1], ca0, ca1);
        e.b0 = 16'(rd_exp(1'b0, 1'b0, ra0, mem_b[ra0], cb0, cb1));
        e.b1 = 16'(rd_exp(1'b0, 1'b0, ra1, mem_b[ra1], cb0, cb1));
        e.b2 = 16'(rd_exp(1'b0, 1'b0, ra2, mem_b[ra2], cb0, cb1));
        e.b3 = 16'(rd_exp(1'b0, 1'b0, ra3, mem_b[ra3], cb0, cb1));
        e.ca = 8'(ma);
        e.cb = 8'(mb);
        if (check) sb.push_back(e);
        if (sb.size() > 0) begin
            g = sb.pop_front();
            chk("dout_a0", dout_a[31:0], g.a0);
            chk("dout_a1", dout_a[63:32], g.a1);
            chk("dout_b0", {16'd0, dout_b[15:0]}, {16'd0, g.b0});
            chk("dout_b1", {16'd0, dout_b[31:16]}, {16'd0, g.b1});
            chk("dout_b2", {16'd0, dout_b[47:32]}, {16'd0, g.b2});
            chk("dout_b3", {16'd0, dout_b[63:48]}, {16'd0, g.b3});
            chk("wrcnt_a", {24'd0, cnt_a}, {24'd0, g.ca});
            chk("wrcnt_b", {24'd0, cnt_b}, {24'd0, g.cb});
        end
        // Model state for the coming edge.
        if (r) begin
            for (int i = 0; i < 32; i++) begin
                mem_a[i] = 32'd0;
                mem_b[i] = 32'd0;
            end
            ma = 0;
            mb = 0;
        end else begin
            if (ca0) mem_a[a0] = d0;
            if (ca1) mem_a[a1] = d1;
            if (cb0) mem_b[a0] = {16'd0, d0[15:0]};
            if (cb1) mem_b[a1] = {16'd0, d1[15:0]};
            ma = (ma + int'(ca0) + int'(ca1) > 255) ? 255 : ma + int'(ca0) + int'(ca1);
            mb = (mb + int'(cb0) + int'(cb1) > 255) ? 255 : mb + int'(cb0) + int'(cb1);
        end
    endtask

    initial begin
        rst = 1'b1; we0 = 1'b0; we1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        ra0 = '0; ra1 = '0; ra2 = '0; ra3 = '0;
        ma = 0; mb = 0;

        // Initial reset; contents unknown beforehand, so unchecked.
        step(1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd0, 5'd0, 0);

        // Random traffic.
        for (int i = 0; i < 12; i++) begin
            step(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1);
        end

        // Reset with a write to reg 5 pending: write dropped, bypass suppressed.
        step(1, 1, 5'd5, 32'h12345678, 1, 5'd6, 32'h9ABCDEF0, 5'd5, 5'd6, 5'd5, 5'd6, 1);
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd5, 5'd6, 5'd5, 5'd1, 1);

        // Basic write then read back.
        step(0, 1, 5'd1, 32'hF0F0F0F0, 0, 5'd0, 32'd0, 5'd1, 5'd2, 5'd1, 5'd0, 1);
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd1, 5'd1, 5'd1, 5'd1, 1);

        // Collision: port 1 wins.
        step(0, 1, 5'd3, 32'h11111111, 1, 5'd3, 32'h22222222, 5'd3, 5'd3, 5'd3, 5'd1, 1);
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd3, 5'd1, 5'd3, 5'd3, 1);

        // Dual commit to distinct addresses.
        step(0, 1, 5'd4, 32'hAAAA0000, 1, 5'd7, 32'h0000BBBB, 5'd4, 5'd7, 5'd4, 5'd7, 1);
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd4, 5'd7, 5'd4, 5'd7, 1);

        // Zero register writes, then bypass vs pre-edge read on address 2.
        step(0, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1);
        step(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 5'd0, 1);
        step(0, 1, 5'd2, 32'h0F0F0F0F, 0, 5'd0, 32'd0, 5'd0, 5'd2, 5'd2, 5'd0, 1);
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd2, 5'd2, 5'd0, 1);

        // Saturation: 300 committed writes on every instance.
        for (int i = 0; i < 150; i++) begin
            step(0, 1, 5'($urandom_range(1, 15)), $urandom, 1, 5'($urandom_range(16, 31)), $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 5'd9, $urandom, 1, 5'd20, $urandom, 5'd9, 5'd20, 5'd9, 5'd20, 1);
        end

        // Reset mid-sequence clears everything.
        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd9, 5'd20, 5'd4, 5'd7, 1);
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd9, 5'd20, 5'd4, 5'd7, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
